cus19_control_unit: RTL and testbench
=====================================

// Module: cus19_control_unit
// PURPOSE
//  Main instruction decoder of the Custom-19 (19-bit) CPU, placed between instruction fetch and execute.
//  Decodes opcode_in/funct_in into datapath controls: ALU, data memory, write-back, PC source, branch,
//  and crypto-accelerator start/mode. All outputs are registered: one-cycle decode latency.
// PARAMETERS
//  none. Widths are fixed by the ISA: opcode 3 bits, funct 4 bits, pc_src 3 bits.
// PORTS
//  clk_in           in   1  system clock; single clock domain, rising edge
//  rst_in           in   1  asynchronous, active-high reset
//  opcode_in        in   3  instruction class: 000 R, 001 M, 010 J, 011 B, 100 S, 101-111 reserved
//  funct_in         in   4  sub-operation within the class
//  alu_en_out       out  1  enable ALU block
//  mem_rd_out       out  1  data-memory read (LOAD, RETURN stack pop)
//  mem_wr_out       out  1  data-memory write (STORE, CALL stack push)
//  reg_wr_out       out  1  register-file write enable
//  wr_back_sel_out  out  1  write-back source: 0 = ALU result, 1 = memory data
//  pc_src_out       out  3  next-PC select: 000 PC+1, 001 jump, 010 call, 011 return, 100 branch
//  branch_en_out    out  1  conditional branch; PC takes the branch target only if the ALU compare is true
//  start_out        out  1  crypto accelerator start
//  mode_enc_dec_out out  1  crypto mode: 0 = encrypt, 1 = decrypt
// BEHAVIOUR
//  - On rst_in high (async), every output is forced to 0, including pc_src_out = 000 (NOP).
//    The outputs hold 0 while reset is asserted.
//  - On each clk_in rising edge, the outputs load the decode of the current opcode_in/funct_in.
//    Latency is exactly 1 cycle. There is no handshake. A stable input holds stable outputs.
//  - Every output not listed below for a class is 0 (NOP default).
//  - R 000, any funct:  alu_en=1, reg_wr=1, wr_back_sel=0, pc_src=000. The ALU interprets funct.
//  - M 001:
//      funct 0 STORE: mem_wr=1.
//      funct 1 LOAD:  mem_rd=1, reg_wr=1, wr_back_sel=1.
//  - J 010:
//      funct 0 JUMP:   pc_src=001.
//      funct 1 CALL:   pc_src=010, mem_wr=1.
//      funct 2 RETURN: pc_src=011, mem_rd=1.
//  - B 011, funct 0 BEQ or 1 BNE: alu_en=1 (compare), branch_en=1, pc_src=100.
//  - S 100, funct 0 ENC or 1 DEC: start=1, mode_enc_dec=funct_in[0].
//    start_out is a level that stays high while an S instruction is decoded.
//  - Illegal combinations decode to the all-zero NOP:
//      undefined funct in the M, J, B or S classes;
//      reserved opcodes 101-111.
//  - Invariants, to be asserted:
//      mem_rd and mem_wr are never both 1;
//      branch_en=1 implies pc_src=100;
//      start=1 implies reg_wr=0 and mem_wr=0.
//  - Reset deassertion mid-stream: the first rising edge after release loads the live decode; no stale state.
// CONFIGURATION
//  - Macro CUS19_CU_ILLEGAL_FLAG_EN.
//  - Defined: adds output illegal_op_out (1 bit). It is registered with the same 1-cycle latency and reset to 0.
//    It is 1 for every illegal combination listed in BEHAVIOUR; the other outputs are still NOP.
//  - Undefined: the port does not exist, and illegal combinations silently decode to NOP.
// STRUCTURE
//  - Package cus19_pkg holds:
//      opcode constants OP_R/OP_M/OP_J/OP_B/OP_S;
//      funct constants F_STORE/F_LOAD/F_JUMP/F_CALL/F_RET/F_BEQ/F_BNE/F_ENC/F_DEC;
//      pc_src encodings PC_INC/PC_JMP/PC_CALL/PC_RET/PC_BR;
//      a packed control-bundle typedef.
//  - One sub-module, cus19_decode_comb: purely combinational decode producing the control bundle.
//    The top level registers the bundle and applies the async reset.
// TESTING
//  - rst_in=1 with arbitrary inputs -> all outputs 0 immediately, without waiting for a clock edge.
//    Release reset, opcode=000 funct=0110 -> after one edge: alu_en=1, reg_wr=1, wr_back_sel=0, pc_src=000.
//  - opcode=001 funct=0 -> mem_wr=1 only. Then funct=1 -> mem_rd=1, reg_wr=1, wr_back_sel=1, mem_wr=0.
//  - opcode=010 with funct 0/1/2 -> pc_src=001 / 010 (mem_wr=1) / 011 (mem_rd=1), each one edge later.
//  - opcode=011 funct=0 -> alu_en=1, branch_en=1, pc_src=100.
//    Then opcode=100 funct=1 -> start=1, mode_enc_dec=1, branch_en=0.
//  - opcode=110, and opcode=001 with funct=1111 -> all outputs 0 (illegal_op_out=1 when the macro is defined).
//    Then assert rst_in mid-instruction -> outputs 0 asynchronously.
//  - Random opcode/funct for at least 1000 cycles: check the outputs against a reference decode model.
//    Check the three invariants every cycle.

Source files
------------

// File: rtl/cus19_pkg.sv
//------------------------------------------------------------------------------
// Module   : cus19_pkg
// Brief    : Custom-19 ISA decode constants and the registered control bundle.
//            Optional macro CUS19_CU_ILLEGAL_FLAG_EN adds an illegal-op flag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cus19_pkg;

   localparam logic [2:0] OP_R = 3'b000;
   localparam logic [2:0] OP_M = 3'b001;
   localparam logic [2:0] OP_J = 3'b010;
   localparam logic [2:0] OP_B = 3'b011;
   localparam logic [2:0] OP_S = 3'b100;

   localparam logic [3:0] F_STORE = 4'd0;
   localparam logic [3:0] F_LOAD  = 4'd1;
   localparam logic [3:0] F_JUMP  = 4'd0;
   localparam logic [3:0] F_CALL  = 4'd1;
   localparam logic [3:0] F_RET   = 4'd2;
   localparam logic [3:0] F_BEQ   = 4'd0;
   localparam logic [3:0] F_BNE   = 4'd1;
   localparam logic [3:0] F_ENC   = 4'd0;
   localparam logic [3:0] F_DEC   = 4'd1;

   localparam logic [2:0] PC_INC  = 3'b000;
   localparam logic [2:0] PC_JMP  = 3'b001;
   localparam logic [2:0] PC_CALL = 3'b010;
   localparam logic [2:0] PC_RET  = 3'b011;
   localparam logic [2:0] PC_BR   = 3'b100;

   typedef struct packed {
      logic       alu_en;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic       wr_back_sel;
      logic [2:0] pc_src;
      logic       branch_en;
      logic       start;
      logic       mode_enc_dec;
`ifdef CUS19_CU_ILLEGAL_FLAG_EN
      logic       illegal_op;
`endif
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/cus19_decode_comb.sv
//------------------------------------------------------------------------------
// Module   : cus19_decode_comb
// Brief    : Purely combinational opcode/funct decode into the control bundle.
//            Macro CUS19_CU_ILLEGAL_FLAG_EN enables the illegal-op field.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cus19_decode_comb
   import cus19_pkg::*;
(
   input  logic [2:0] i_opcode,
   input  logic [3:0] i_funct,
   output ctrl_t      o_ctrl
);

   logic w_legal;

   always_comb begin
      o_ctrl  = '0;
      w_legal = 1'b1;
      case (i_opcode)
         OP_R: begin
            o_ctrl.alu_en = 1'b1;
            o_ctrl.reg_wr = 1'b1;
         end
         OP_M: begin
            case (i_funct)
               F_STORE: o_ctrl.mem_wr = 1'b1;
               F_LOAD: begin
                  o_ctrl.mem_rd      = 1'b1;
                  o_ctrl.reg_wr      = 1'b1;
                  o_ctrl.wr_back_sel = 1'b1;
               end
               default: w_legal = 1'b0;
            endcase
         end
         OP_J: begin
            case (i_funct)
               F_JUMP: o_ctrl.pc_src = PC_JMP;
               F_CALL: begin
                  o_ctrl.pc_src = PC_CALL;
                  o_ctrl.mem_wr = 1'b1;
               end
               F_RET: begin
                  o_ctrl.pc_src = PC_RET;
                  o_ctrl.mem_rd = 1'b1;
               end
               default: w_legal = 1'b0;
            endcase
         end
         OP_B: begin
            if (i_funct == F_BEQ || i_funct == F_BNE) begin
               o_ctrl.alu_en    = 1'b1;
               o_ctrl.branch_en = 1'b1;
               o_ctrl.pc_src    = PC_BR;
            end else begin
               w_legal = 1'b0;
            end
         end
         OP_S: begin
            if (i_funct == F_ENC || i_funct == F_DEC) begin
               o_ctrl.start        = 1'b1;
               o_ctrl.mode_enc_dec = i_funct[0];
            end else begin
               w_legal = 1'b0;
            end
         end
         default: w_legal = 1'b0;
      endcase
`ifdef CUS19_CU_ILLEGAL_FLAG_EN
      o_ctrl.illegal_op = ~w_legal;
`endif
   end

`ifndef CUS19_CU_ILLEGAL_FLAG_EN
   // Legality is only consumed when the flag output is built.
   logic w_unused;
   assign w_unused = w_legal;
`endif

endmodule

`default_nettype wire

// File: rtl/cus19_control_unit.sv
//------------------------------------------------------------------------------
// Module   : cus19_control_unit
// Brief    : Custom-19 main decoder; registers the decoded bundle (1-cycle
//            latency). Macro CUS19_CU_ILLEGAL_FLAG_EN adds illegal_op_out.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cus19_control_unit
   import cus19_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [2:0] opcode_in,
   input  logic [3:0] funct_in,
   output logic       alu_en_out,
   output logic       mem_rd_out,
   output logic       mem_wr_out,
   output logic       reg_wr_out,
   output logic       wr_back_sel_out,
   output logic [2:0] pc_src_out,
   output logic       branch_en_out,
   output logic       start_out,
`ifdef CUS19_CU_ILLEGAL_FLAG_EN
   output logic       illegal_op_out,
`endif
   output logic       mode_enc_dec_out
);

   ctrl_t w_ctrl;
   ctrl_t r_ctrl;

   cus19_decode_comb u_decode (
      .i_opcode (opcode_in),
      .i_funct  (funct_in),
      .o_ctrl   (w_ctrl)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_ctrl <= '0;
      else        r_ctrl <= w_ctrl;
   end

   assign alu_en_out       = r_ctrl.alu_en;
   assign mem_rd_out       = r_ctrl.mem_rd;
   assign mem_wr_out       = r_ctrl.mem_wr;
   assign reg_wr_out       = r_ctrl.reg_wr;
   assign wr_back_sel_out  = r_ctrl.wr_back_sel;
   assign pc_src_out       = r_ctrl.pc_src;
   assign branch_en_out    = r_ctrl.branch_en;
   assign start_out        = r_ctrl.start;
   assign mode_enc_dec_out = r_ctrl.mode_enc_dec;
`ifdef CUS19_CU_ILLEGAL_FLAG_EN
   assign illegal_op_out   = r_ctrl.illegal_op;
`endif

   a_mem_excl: assert property (@(posedge clk_in) disable iff (rst_in)
      !(mem_rd_out && mem_wr_out));
   a_branch_pc: assert property (@(posedge clk_in) disable iff (rst_in)
      branch_en_out |-> (pc_src_out == PC_BR));
   a_start_nowr: assert property (@(posedge clk_in) disable iff (rst_in)
      start_out |-> (!reg_wr_out && !mem_wr_out));

endmodule

`default_nettype wire

// File: tb/tb_cus19_control_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_cus19_control_unit
// Brief    : Self-checking bench for cus19_control_unit; honours the optional
//            CUS19_CU_ILLEGAL_FLAG_EN macro.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cus19_control_unit;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic [2:0] opcode_in;
   logic [3:0] funct_in;
   logic       alu_en_out, mem_rd_out, mem_wr_out, reg_wr_out, wr_back_sel_out;
   logic [2:0] pc_src_out;
   logic       branch_en_out, start_out, mode_enc_dec_out;
   logic       illegal_op_out;

   int checks   = 0;
   int failures = 0;

   // Reference: table of every legal instruction; anything absent is a NOP.
   logic [10:0] ref_tbl [logic [6:0]];

   logic [10:0] w_got;
   assign w_got = {alu_en_out, mem_rd_out, mem_wr_out, reg_wr_out, wr_back_sel_out,
                   pc_src_out, branch_en_out, start_out, mode_enc_dec_out};

   cus19_control_unit dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .opcode_in        (opcode_in),
      .funct_in         (funct_in),
      .alu_en_out       (alu_en_out),
      .mem_rd_out       (mem_rd_out),
      .mem_wr_out       (mem_wr_out),
      .reg_wr_out       (reg_wr_out),
      .wr_back_sel_out  (wr_back_sel_out),
      .pc_src_out       (pc_src_out),
      .branch_en_out    (branch_en_out),
      .start_out        (start_out),
`ifdef CUS19_CU_ILLEGAL_FLAG_EN
      .illegal_op_out   (illegal_op_out),
`endif
      .mode_enc_dec_out (mode_enc_dec_out)
   );

`ifndef CUS19_CU_ILLEGAL_FLAG_EN
   assign illegal_op_out = 1'b0;
`endif

   always #5 clk_in = ~clk_in;

   function automatic logic [10:0] mk(input logic alu, input logic rd, input logic wr,
                                      input logic rw, input logic wbs, input logic [2:0] pc,
                                      input logic br, input logic st, input logic md);
      return {alu, rd, wr, rw, wbs, pc, br, st, md};
   endfunction

   function automatic logic [10:0] ref_decode(input logic [2:0] op, input logic [3:0] f);
      if (ref_tbl.exists({op, f})) return ref_tbl[{op, f}];
      return 11'd0;
   endfunction

   function automatic logic ref_illegal(input logic [2:0] op, input logic [3:0] f);
`ifdef CUS19_CU_ILLEGAL_FLAG_EN
      return !ref_tbl.exists({op, f});
`else
      return 1'b0;
`endif
   endfunction

   task automatic build_table();
      for (int f = 0; f < 16; f++)
         ref_tbl[{3'b000, 4'(f)}] = mk(1, 0, 0, 1, 0, 3'b000, 0, 0, 0);
      ref_tbl[{3'b001, 4'd0}] = mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
      ref_tbl[{3'b001, 4'd1}] = mk(0, 1, 0, 1, 1, 3'b000, 0, 0, 0);
      ref_tbl[{3'b010, 4'd0}] = mk(0, 0, 0, 0, 0, 3'b001, 0, 0, 0);
      ref_tbl[{3'b010, 4'd1}] = mk(0, 0, 1, 0, 0, 3'b010, 0, 0, 0);
      ref_tbl[{3'b010, 4'd2}] = mk(0, 1, 0, 0, 0, 3'b011, 0, 0, 0);
      ref_tbl[{3'b011, 4'd0}] = mk(1, 0, 0, 0, 0, 3'b100, 1, 0, 0);
      ref_tbl[{3'b011, 4'd1}] = mk(1, 0, 0, 0, 0, 3'b100, 1, 0, 0);
      ref_tbl[{3'b100, 4'd0}] = mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 0);
      ref_tbl[{3'b100, 4'd1}] = mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 1);
   endtask

   task automatic apply(input logic [2:0] op, input logic [3:0] f);
      @(negedge clk_in);
      opcode_in = op;
      funct_in  = f;
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; opcode_in = 3'b000; funct_in = 4'b0110;
      #2;
      checks++;
      if (w_got !== 11'd0 || illegal_op_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got=%b ill=%b want=0", w_got, illegal_op_out);
      end
      @(negedge clk_in);
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      checks++;
      if (w_got !== mk(1, 0, 0, 1, 0, 3'b000, 0, 0, 0)) begin
         failures++;
         $display("FAIL reset_release_r: got=%b want=%b", w_got, mk(1, 0, 0, 1, 0, 3'b000, 0, 0, 0));
      end
   endtask

   task automatic test_directed();
      logic [2:0]  ops [8]  = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b011, 3'b100, 3'b100};
      logic [3:0]  fs  [8]  = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd0};
      logic [10:0] exp [8]  = '{mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 0),
                                mk(0, 1, 0, 1, 1, 3'b000, 0, 0, 0),
                                mk(0, 0, 0, 0, 0, 3'b001, 0, 0, 0),
                                mk(0, 0, 1, 0, 0, 3'b010, 0, 0, 0),
                                mk(0, 1, 0, 0, 0, 3'b011, 0, 0, 0),
                                mk(1, 0, 0, 0, 0, 3'b100, 1, 0, 0),
                                mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 1),
                                mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 0)};
      for (int i = 0; i < 8; i++) begin
         apply(ops[i], fs[i]);
         checks++;
         if (w_got !== exp[i] || illegal_op_out !== 1'b0) begin
            failures++;
            $display("FAIL directed op=%b f=%h: got=%b ill=%b want=%b ill=0",
                     ops[i], fs[i], w_got, illegal_op_out, exp[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [2:0] ops [4] = '{3'b110, 3'b001, 3'b011, 3'b111};
      logic [3:0] fs  [4] = '{4'd0, 4'hF, 4'd2, 4'd5};
      logic       exp_ill;
`ifdef CUS19_CU_ILLEGAL_FLAG_EN
      exp_ill = 1'b1;
`else
      exp_ill = 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
         apply(ops[i], fs[i]);
         checks++;
         if (w_got !== 11'd0 || illegal_op_out !== exp_ill) begin
            failures++;
            $display("FAIL illegal op=%b f=%h: got=%b ill=%b want=0 ill=%b",
                     ops[i], fs[i], w_got, illegal_op_out, exp_ill);
         end
      end
   endtask

   task automatic test_mid_reset();
      apply(3'b010, 4'd1);
      rst_in = 1'b1;
      #1;
      checks++;
      if (w_got !== 11'd0 || illegal_op_out !== 1'b0) begin
         failures++;
         $display("FAIL async_mid_reset: got=%b ill=%b want=0", w_got, illegal_op_out);
      end
      repeat (2) @(posedge clk_in);
      #1;
      checks++;
      if (w_got !== 11'd0) begin
         failures++;
         $display("FAIL reset_hold: got=%b want=0", w_got);
      end
      @(negedge clk_in);
      rst_in = 1'b0; opcode_in = 3'b100; funct_in = 4'd0;
      @(posedge clk_in);
      #1;
      checks++;
      if (w_got !== mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 0)) begin
         failures++;
         $display("FAIL release_live_decode: got=%b want=%b", w_got, mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 0));
      end
   endtask

   task automatic test_random();
      logic [2:0] op;
      logic [3:0] f;
      for (int n = 0; n < 1200; n++) begin
         op = 3'($urandom_range(0, 7));
         f  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         apply(op, f);
         checks++;
         if (w_got !== ref_decode(op, f) || illegal_op_out !== ref_illegal(op, f)) begin
            failures++;
            $display("FAIL random op=%b f=%h: got=%b ill=%b want=%b ill=%b",
                     op, f, w_got, illegal_op_out, ref_decode(op, f), ref_illegal(op, f));
         end
         checks++;
         if (mem_rd_out === 1'b1 && mem_wr_out === 1'b1) begin
            failures++;
            $display("FAIL inv_mem_excl: rd=%b wr=%b want not both", mem_rd_out, mem_wr_out);
         end
         checks++;
         if (branch_en_out === 1'b1 && pc_src_out !== 3'b100) begin
            failures++;
            $display("FAIL inv_branch_pc: pc_src=%b want 100", pc_src_out);
         end
         checks++;
         if (start_out === 1'b1 && (reg_wr_out !== 1'b0 || mem_wr_out !== 1'b0)) begin
            failures++;
            $display("FAIL inv_start_nowr: reg_wr=%b mem_wr=%b want 0 0", reg_wr_out, mem_wr_out);
         end
      end
   endtask

   initial begin
      build_table();
      test_reset();
      test_directed();
      test_illegal();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
